// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and constants for the in-order CPU pipeline.
//            Holds the writeback-stage state encoding and the load funct3
//            codes used by the load aligner.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Writeback stage FSM states
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,   // no instruction held
        HOLD_ALU  = 2'd1,   // non-load instruction, retires this cycle
        WAIT_LOAD = 2'd2    // load held, waiting for data memory
    } wb_state_e;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/load_aligner.sv
`default_nettype none
// ============================================================================
// Module   : load_aligner
// Purpose  : Combinational load data alignment and sign/zero extension.
// Ports    : funct3  [2:0]  load type (LB/LH/LW/LBU/LHU, others as LW)
//            addr_lo [1:0]  byte offset of the load address
//            rdata   [31:0] raw word from data memory
//            data    [31:0] aligned, extended result
// Revision : 1.0 - initial release
// ============================================================================
module load_aligner
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Halfword selection uses only addr_lo[1]; misaligned bit 0 is ignored
    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  data = {24'd0, w_byte};
            F3_LH:   data = {{16{w_half[15]}}, w_half};
            F3_LHU:  data = {16'd0, w_half};
            // LW and the unused codes all return the full word
            default: data = rdata;
        endcase
    end

endmodule : load_aligner
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Writeback stage. Holds the MEM/WB pipeline register, aligns
//            load data, stalls while a load is outstanding, drives the
//            register-file write port, a forwarding tap and instret.
// Ports    : clk, rst (async, active-low)
//            m_valid/m_ready handshake with MEM, m_* instruction fields
//            dm_rvalid/dm_rdata  load data return
//            wb_en/W_rd_index/wb_data  register-file write port
//            fwd_valid/fwd_rd/fwd_data  bypass copy of the write port
//            wb_stall = !m_ready, instret = retired instruction count
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic            m_reg_write,
    input  logic            m_is_load,
    input  logic [2:0]      m_funct3,
    input  logic [1:0]      m_addr_lo,
    input  logic [4:0]      m_rd_index,
    input  logic [XLEN-1:0] m_alu_result,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            wb_en,
    output logic [4:0]      W_rd_index,
    output logic [XLEN-1:0] wb_data,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            wb_stall,
    output logic [63:0]     instret
);

    wb_state_e       r_state;
    wb_state_e       w_next_state;
    logic            r_reg_write;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_alu_result;
    logic [63:0]     r_instret;

    logic            w_retire;
    logic            w_xfer;
    logic [XLEN-1:0] w_load_data;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (w_xfer) begin
            w_next_state = m_is_load ? WAIT_LOAD : HOLD_ALU;
        end else if (w_retire) begin
            w_next_state = EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        m_ready  = 1'b1;
        w_retire = 1'b0;
        case (r_state)
            EMPTY: begin
                m_ready  = 1'b1;
                w_retire = 1'b0;
            end
            HOLD_ALU: begin
                m_ready  = 1'b1;
                w_retire = 1'b1;
            end
            WAIT_LOAD: begin
                // A retiring load frees the stage in the same cycle
                m_ready  = dm_rvalid;
                w_retire = dm_rvalid;
            end
            default: begin
                m_ready  = 1'b1;
                w_retire = 1'b0;
            end
        endcase
    end

    assign w_xfer   = m_valid && m_ready;
    assign wb_stall = !m_ready;

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr_lo    <= 2'd0;
            r_rd         <= 5'd0;
            r_alu_result <= '0;
        end else if (w_xfer) begin
            r_reg_write  <= m_reg_write;
            r_funct3     <= m_funct3;
            r_addr_lo    <= m_addr_lo;
            r_rd         <= m_rd_index;
            r_alu_result <= m_alu_result;
        end
    end

    // ------------------------------------------------------------------
    // Retired instruction counter (wraps naturally at 2^64)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= 64'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;

    load_aligner u_load_aligner (
        .funct3  (r_funct3),
        .addr_lo (r_addr_lo),
        .rdata   (dm_rdata),
        .data    (w_load_data)
    );

    // ------------------------------------------------------------------
    // Register-file write port; index and data read as zero unless an
    // instruction retires so a stalled load never shows stale values.
    // ------------------------------------------------------------------
    assign wb_en      = w_retire && r_reg_write && (r_rd != 5'd0);
    assign W_rd_index = w_retire ? r_rd : 5'd0;
    assign wb_data    = !w_retire              ? '0 :
                        (r_state == WAIT_LOAD) ? w_load_data : r_alu_result;

    assign fwd_valid  = wb_en;
    assign fwd_rd     = W_rd_index;
    assign fwd_data   = wb_data;

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Self-checking bench for wb_stage: reset values, ALU stream,
//            load alignment table, load stall, reset mid-load, stray data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        m_valid;
    logic        m_ready;
    logic        m_reg_write;
    logic        m_is_load;
    logic [2:0]  m_funct3;
    logic [1:0]  m_addr_lo;
    logic [4:0]  m_rd_index;
    logic [31:0] m_alu_result;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_en;
    logic [4:0]  W_rd_index;
    logic [31:0] wb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        wb_stall;
    logic [63:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    wb_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_reg_write  (m_reg_write),
        .m_is_load    (m_is_load),
        .m_funct3     (m_funct3),
        .m_addr_lo    (m_addr_lo),
        .m_rd_index   (m_rd_index),
        .m_alu_result (m_alu_result),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata),
        .wb_en        (wb_en),
        .W_rd_index   (W_rd_index),
        .wb_data      (wb_data),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .wb_stall     (wb_stall),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one full cycle; inputs are always driven on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        m_valid      = 1'b0;
        m_reg_write  = 1'b0;
        m_is_load    = 1'b0;
        m_funct3     = 3'd0;
        m_addr_lo    = 2'd0;
        m_rd_index   = 5'd0;
        m_alu_result = 32'd0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
        m_valid      = 1'b1;
        m_reg_write  = 1'b1;
        m_is_load    = 1'b0;
        m_funct3     = 3'd0;
        m_addr_lo    = 2'd0;
        m_rd_index   = rd;
        m_alu_result = res;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo);
        m_valid      = 1'b1;
        m_reg_write  = 1'b1;
        m_is_load    = 1'b1;
        m_funct3     = f3;
        m_addr_lo    = alo;
        m_rd_index   = rd;
        m_alu_result = 32'hDEAD_BEEF;
    endtask

    logic [63:0] base;

    initial begin
        // LB/LH/LW/LBU/LHU = 000/001/010/100/101; word bytes b3..b0 = 80 FF 12 34
        vecs[0] = '{3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[1] = '{3'b100, 2'd3, 32'h80FF_1234, 32'h0000_0080};
        vecs[2] = '{3'b101, 2'd2, 32'h80FF_1234, 32'h0000_80FF};
        vecs[3] = '{3'b001, 2'd1, 32'h80FF_1234, 32'h0000_1234};
        vecs[4] = '{3'b001, 2'd3, 32'h80FF_1234, 32'hFFFF_80FF};
        vecs[5] = '{3'b010, 2'd3, 32'h80FF_1234, 32'h80FF_1234};
        vecs[6] = '{3'b011, 2'd1, 32'h80FF_1234, 32'h80FF_1234};
        vecs[7] = '{3'b000, 2'd0, 32'h80FF_1234, 32'h0000_0034};
        vecs[8] = '{3'b000, 2'd2, 32'h80FF_1234, 32'hFFFF_FFFF};
        vecs[9] = '{3'b100, 2'd1, 32'h80FF_1234, 32'h0000_0012};

        drive_idle();
        dm_rvalid = 1'b0;
        dm_rdata  = 32'd0;
        rst       = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_wb_en",    {63'd0, wb_en},      64'd0);
        check("rst_rd",       {59'd0, W_rd_index}, 64'd0);
        check("rst_data",     {32'd0, wb_data},    64'd0);
        check("rst_fwd",      {26'd0, fwd_valid, fwd_rd, fwd_data}, 64'd0);
        check("rst_m_ready",  {63'd0, m_ready},    64'd1);
        check("rst_stall",    {63'd0, wb_stall},   64'd0);
        check("rst_instret",  instret,             64'd0);
        rst = 1'b1;
        tick(); tick(); tick();
        check("idle_instret", instret,             64'd0);
        check("idle_wb_en",   {63'd0, wb_en},      64'd0);

        // ---------------- ALU stream ----------------
        drive_alu(5'd5, 32'h11);
        check("alu_rdy0", {63'd0, m_ready}, 64'd1);
        tick();
        drive_alu(5'd6, 32'h22);
        check("alu_en5",   {63'd0, wb_en},      64'd1);
        check("alu_rd5",   {59'd0, W_rd_index}, 64'd5);
        check("alu_d5",    {32'd0, wb_data},    64'h11);
        check("alu_fwd5",  {26'd0, fwd_valid, fwd_rd, fwd_data}, {26'd0, 1'b1, 5'd5, 32'h11});
        check("alu_rdy1",  {63'd0, m_ready},    64'd1);
        tick();
        drive_alu(5'd0, 32'h33);
        check("alu_en6",   {63'd0, wb_en},      64'd1);
        check("alu_rd6",   {59'd0, W_rd_index}, 64'd6);
        check("alu_d6",    {32'd0, wb_data},    64'h22);
        check("alu_rdy2",  {63'd0, m_ready},    64'd1);
        tick();
        drive_idle();
        check("alu_x0_en", {63'd0, wb_en},      64'd0);
        check("alu_rdy3",  {63'd0, m_ready},    64'd1);
        check("alu_ir2",   instret,             64'd2);
        tick();
        check("alu_ir3",   instret,             64'd3);
        check("alu_empty", {63'd0, wb_en},      64'd0);

        // ---------------- stray data ----------------
        drive_alu(5'd9, 32'h0000_ABCD);
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h1111_2222;
        check("stray_empty_rdy", {63'd0, m_ready}, 64'd1);
        check("stray_empty_en",  {63'd0, wb_en},   64'd0);
        tick();
        drive_idle();
        dm_rdata = 32'hDEAD_0001;
        check("stray_hold_en",   {63'd0, wb_en},   64'd1);
        check("stray_hold_d",    {32'd0, wb_data}, 64'h0000_ABCD);
        tick();
        check("stray_ir",        instret,          64'd4);
        dm_rvalid = 1'b0;

        // ---------------- load alignment table ----------------
        for (int i = 0; i < 10; i++) begin
            drive_load(5'd10, vecs[i].f3, vecs[i].alo);
            tick();
            drive_idle();
            check($sformatf("ld%0d_wait_en", i), {63'd0, wb_en}, 64'd0);
            check($sformatf("ld%0d_stall", i),   {63'd0, wb_stall}, 64'd1);
            dm_rvalid = 1'b1;
            dm_rdata  = vecs[i].rdata;
            #1;
            check($sformatf("ld%0d_en", i),   {63'd0, wb_en},   64'd1);
            check($sformatf("ld%0d_data", i), {32'd0, wb_data}, {32'd0, vecs[i].exp});
            tick();
            dm_rvalid = 1'b0;
        end
        check("ld_instret", instret, 64'd14);

        // ---------------- load stall with waiting ALU instruction ----------------
        base = instret;
        drive_load(5'd7, 3'b010, 2'd0);
        tick();
        drive_alu(5'd8, 32'h77);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall%0d_stall", c), {63'd0, wb_stall}, 64'd1);
            check($sformatf("stall%0d_rdy", c),   {63'd0, m_ready},  64'd0);
            check($sformatf("stall%0d_en", c),    {63'd0, wb_en},    64'd0);
            tick();
        end
        check("stall_hold_ir", instret, base);
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h1234_5678;
        #1;
        check("stall_x7_en",   {63'd0, wb_en},      64'd1);
        check("stall_x7_rd",   {59'd0, W_rd_index}, 64'd7);
        check("stall_x7_d",    {32'd0, wb_data},    64'h1234_5678);
        check("stall_release", {63'd0, wb_stall},   64'd0);
        tick();
        dm_rvalid = 1'b0;
        drive_idle();
        check("stall_x8_en", {63'd0, wb_en},      64'd1);
        check("stall_x8_rd", {59'd0, W_rd_index}, 64'd8);
        check("stall_x8_d",  {32'd0, wb_data},    64'h77);
        tick();
        check("stall_ir", instret, base + 64'd2);

        // ---------------- reset mid-load ----------------
        drive_load(5'd11, 3'b010, 2'd0);
        tick();
        drive_idle();
        check("rml_stall", {63'd0, wb_stall}, 64'd1);
        rst = 1'b0;
        #1;
        check("rml_async_ir",  instret,            64'd0);
        check("rml_async_rdy", {63'd0, m_ready},   64'd1);
        tick();
        rst       = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata  = 32'hCAFE_F00D;
        #1;
        check("rml_en",   {63'd0, wb_en},      64'd0);
        check("rml_rd",   {59'd0, W_rd_index}, 64'd0);
        check("rml_rdy",  {63'd0, m_ready},    64'd1);
        tick();
        dm_rvalid = 1'b0;
        check("rml_ir",   instret,             64'd0);
        check("rml_en2",  {63'd0, wb_en},      64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_wb_stage
`default_nettype wire
